reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
- Shares the single write path into a bank of NUM_REGS 32-bit load-enabled registers between NUM_REQ requesters. Example requesters are the ALU writeback, memory load return, the PC/link update and the debug port.
- Arbitrates round-robin, captures the winner's address and data, and drives a one-hot loadEnable vector plus a shared inputData bus into the register instances.
- Returns a one-cycle ack to the winner.
- Sits between the datapath producers and the register bank. The registers keep their own clk/rst and are not modified.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_REGS, 8, number of registers driven (≤ 2^ADDR_W)
- DATA_W, 32, register data width
- ADDR_W, 3, register index width
- REQ_IDX_W, 2, width of grantId (clog2 NUM_REQ)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester write request, level, held until ack
- reqAddr  in  NUM_REQ*ADDR_W  packed target register index; requester i uses slice i
- reqData  in  NUM_REQ*DATA_W  packed write data; requester i uses slice i
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- loadEnable  out  NUM_REGS  one-hot register load enable, to the register instances
- inputData  out  DATA_W  shared data bus, to the register instances
- grantId  out  REQ_IDX_W  index of the current or last granted requester
- busy  out  1  high whenever state != IDLE
- errAddr  out  1  one-cycle pulse, granted address ≥ NUM_REGS

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst). All outputs are registered.
- Reset values: state=IDLE, ack=0, loadEnable=0, inputData=0, grantId=0, busy=0, errAddr=0, rrPtr=0.
- FSM, 2-bit state:
  - IDLE: if any req bit is set, pick the winner: the first set bit scanning rrPtr, rrPtr+1, … mod NUM_REQ. Capture the winner's reqAddr/reqData into capAddr/capData, set grantId=winner, go to WRITE. If no req is set, stay in IDLE with all outputs idle.
  - WRITE (1 cycle): if capAddr < NUM_REGS, loadEnable[capAddr]=1 and all other bits are 0. inputData=capData. The register loads capData on the edge that ends WRITE. If capAddr ≥ NUM_REGS, loadEnable=0 and errAddr=1 for this cycle. Next state is ACK.
  - ACK (1 cycle): ack[grantId]=1, loadEnable=0. rrPtr is set to (grantId+1) mod NUM_REQ. Next state is IDLE.
- Latency: req sampled high in IDLE at edge E leads to loadEnable at E+1 (high during WRITE), the register updated at E+2, and ack high during E+2..E+3.
- Throughput: one write per 3 cycles.
- Handshake:
  - Requester holds req, reqAddr and reqData stable until the grant edge only. Data is captured at grant and later changes are ignored.
  - Requester drops req in the cycle after ack. A req still high in the IDLE following ACK is a new request and causes a repeat write.
- inputData holds capData after WRITE, until the next grant; it is not zeroed.
- Fairness: after requester i is served, i has the lowest priority. With all requesters permanently requesting, grants rotate 0,1,2,3,0,…
- Requests arriving during WRITE or ACK are not sampled until IDLE. Deassertion of the granted req after the grant does not cancel the write.
- Reset mid-operation: at the rst edge, state goes to IDLE and loadEnable, ack and errAddr go to 0; a pending write is dropped and no ack is issued. If rst is asserted during WRITE, that cycle's load still occurs at the same edge. This is harmless because the registers share rst and clear on that edge.
- At most one loadEnable bit is ever high; it is never high outside WRITE.

Decomposition:
- Shared package (arb_pkg):
  - State encoding: ST_IDLE=2'b00, ST_WRITE=2'b01, ST_ACK=2'b10. The value 2'b11 is illegal and recovers to IDLE.
  - Default width constants: DATA_W, ADDR_W.
- Sub-module rr_pick:
  - Purely combinational round-robin picker.
  - Inputs: req vector and rrPtr. Outputs: winner index and valid.
  - Parameterised on NUM_REQ.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'b1111 → loadEnable=0, ack=0, busy=0, inputData=0 throughout; after release, first grant goes to requester 0.
- Single write: req[2]=1, reqAddr[2]=5, reqData[2]=32'h0000_0004 → loadEnable=8'b0010_0000 for exactly 1 cycle, inputData=4; register 5 reads 4 on the next edge; ack=4'b0100 for 1 cycle; req dropped → returns to IDLE.
- Round-robin: req=4'b1111 held with addrs 0,1,2,3 and data 1,2,3,4 → grants in order 0,1,2,3,0, each 3 cycles apart; register k ends with value k+1.
- Data capture: req[1] with data 32'h1, changed to 32'h2 one cycle after grant → register loads 1, not 2.
- Bad address (NUM_REGS=6): req[0] with reqAddr=7 → errAddr pulses 1 cycle; loadEnable stays 0; ack[0] still pulses.
- Reset mid-op: assert rst during WRITE of a write of 32'hA to register 3 → no ack issued; register 3 reads 0; the next request is granted normally starting from rrPtr=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the register write arbiter.
// Holds the FSM state encoding and the default data/address widths.
package arb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;

   // ST_BAD is never entered on purpose; it is listed so that the
   // next-state logic can steer it back to idle explicitly.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WRITE = 2'b01,
      ST_ACK   = 2'b10,
      ST_BAD   = 2'b11
   } state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req    in   NUM_REQ  request vector
//   ptr    in   IDX_W    highest-priority index for this pick
//   winner out  IDX_W    first set request at or after ptr (wrapping)
//   valid  out  1        at least one request is set
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   int idx;

   // Scan from the farthest offset down to ptr itself so that the last
   // hit (closest to ptr) overwrites the earlier ones.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (req[idx]) begin
            winner = IDX_W'(idx);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the single write path into a bank of
// load-enabled registers between several requesters, round-robin.
// A grant takes three cycles: IDLE (pick) -> WRITE (load) -> ACK.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a request; picks a winner and captures its data
// ST_WRITE | loadEnable one-hot (or errAddr) for the captured address
// ST_ACK   | ack pulse to the winner, round-robin pointer advances
// ST_BAD   | unreachable; recovers to ST_IDLE
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req           per-requester write request (level, held until ack)
//   reqAddr       packed register index, requester i uses slice i
//   reqData       packed write data, requester i uses slice i
//   ack           one-cycle completion pulse to the winner
//   loadEnable    one-hot register load enable
//   inputData     shared data bus to the registers
//   grantId       current or last granted requester
//   busy          high whenever not idle
//   errAddr       one-cycle pulse when the granted address is out of range
module reg_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int NUM_REGS  = 8,
   parameter int DATA_W    = arb_pkg::DATA_W,
   parameter int ADDR_W    = arb_pkg::ADDR_W,
   parameter int REQ_IDX_W = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*ADDR_W-1:0]   reqAddr,
   input  logic [NUM_REQ*DATA_W-1:0]   reqData,
   output logic [NUM_REQ-1:0]          ack,
   output logic [NUM_REGS-1:0]         loadEnable,
   output logic [DATA_W-1:0]           inputData,
   output logic [REQ_IDX_W-1:0]        grantId,
   output logic                        busy,
   output logic                        errAddr
);

   import arb_pkg::*;

   state_t                 state_q, state_d;
   logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [REQ_IDX_W-1:0]   pick_idx;
   logic                   pick_valid;
   logic [ADDR_W-1:0]      win_addr;
   logic [DATA_W-1:0]      win_data;

   logic [NUM_REQ-1:0]     ack_d;
   logic [NUM_REGS-1:0]    load_d;
   logic [DATA_W-1:0]      data_d;
   logic [REQ_IDX_W-1:0]   grant_d;
   logic                   busy_d;
   logic                   err_d;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (REQ_IDX_W)
   ) u_rr_pick (
      .req    (req),
      .ptr    (rr_ptr_q),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   assign win_addr = reqAddr[int'(pick_idx)*ADDR_W +: ADDR_W];
   assign win_data = reqData[int'(pick_idx)*DATA_W +: DATA_W];

   // Outputs are registered, so the WRITE-cycle outputs are computed while
   // still in IDLE from the winner's inputs. inputData is itself the
   // captured data and grantId the captured winner; no separate copies.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      ack_d    = '0;
      load_d   = '0;
      err_d    = 1'b0;
      data_d   = inputData;
      grant_d  = grantId;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_WRITE;
               grant_d = pick_idx;
               data_d  = win_data;
               if (int'(win_addr) < NUM_REGS) begin
                  for (int r = 0; r < NUM_REGS; r++) begin
                     load_d[r] = (int'(win_addr) == r);
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            state_d       = ST_ACK;
            ack_d[grantId] = 1'b1;
            rr_ptr_d      = (int'(grantId) == NUM_REQ - 1) ? '0 : grantId + 1'b1;
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         ack        <= '0;
         loadEnable <= '0;
         inputData  <= '0;
         grantId    <= '0;
         busy       <= 1'b0;
         errAddr    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         ack        <= ack_d;
         loadEnable <= load_d;
         inputData  <= data_d;
         grantId    <= grant_d;
         busy       <= busy_d;
         errAddr    <= err_d;
      end
   end

endmodule
